mdr_wbuf_slice: RTL and testbench
=================================

Name: mdr_wbuf_slice

Overview:
- Parametrised next-generation memory data register slice with NLANE lanes.
- Captures read data from the cache, CMI or W bus through a lane rotator into the MDR. Supports second-reference partial-lane merge for unaligned reads.
- Queues write data plus physical address in a WDEPTH-entry write buffer, replacing the single WDR.
- Drains the buffer onto the CMI with a request/grant, address-then-data sequencer. Sits between the microsequencer-controlled datapath and the CMI interface.

Parameters:
- NLANE, 4, data lanes (bits) per slice; power of two, at least 4.
- RW, 2, rotate-amount width; equals log2(NLANE).
- AW, 3, physical-address bits per slice.
- WDEPTH, 4, write-buffer entries; power of two, at least 2.

Ports:
- b_clk_l  in  1  datapath clock; all registers update on its rising edge
- reset_h  in  1  asynchronous active-high reset
- wbus_h  in  NLANE  W bus data
- ca_h  in  NLANE  cache data in
- ca_out_h  out  NLANE  cache data out; all ones when not driving
- cmi_h  in  NLANE  CMI data in
- snapshot_cmi_l  in  1  low: capture cmi_h into the CMI data register on the clock
- pa_h  in  AW  physical address in
- are_l  in  1  low: load the address register from pa_h
- ds_h  in  2  D bus source: 00 ca_h, 01 CMI data register, 10 wbus_h, 11 zero
- dr_h  in  RW  rotate-right amount, in lanes
- cs_h  in  2  cycle select: 00 none, 01 load MDR, 10 second-reference merge, 11 push write buffer
- ms_h  in  2  M bus source: 00 MDR, 01 write-buffer head data, 10 wbus_h, 11 zero-extended address register
- mbus_ena_h  in  1  M bus output enable
- mb_l  out  NLANE  M bus, active low
- cmi_grant_h  in  1  CMI grant
- cmi_req_h  out  1  CMI request
- cmi_drv_h  out  1  slice driving cmi_out_h this cycle
- cmi_out_h  out  NLANE  CMI drive data; all ones when not driving
- wbuf_full_h  out  1  write buffer full
- wbuf_empty_h  out  1  write buffer empty
- wbuf_ovf_h  out  1  sticky: a push was attempted while full

Behaviour:
- Reset (asynchronous, reset_h high):
  - MDR, address register and CMI data register cleared to 0.
  - Write buffer empty and its pointers cleared; wbuf_ovf_h cleared to 0.
  - FSM set to IDLE.
  - Outputs: cmi_req_h=0, cmi_drv_h=0, cmi_out_h all ones, wbuf_empty_h=1, wbuf_full_h=0.
  - Reset asserted mid-burst abandons the burst and releases the CMI immediately, with no glitch to driven data.
- D bus and rotator:
  - The D bus is the ds_h selection (ds_h=11 selects all zeros).
  - rot = D bus rotated right by dr_h lanes: rot[i] = dbus[(i+dr_h) mod NLANE].
- MDR update:
  - cs_h=01 loads all lanes with rot.
  - cs_h=10 loads only the top dr_h lanes, [NLANE-1 : NLANE-dr_h]. With dr_h=0 no lane loads.
  - Other cs_h values hold the MDR.
- Write-buffer push:
  - cs_h=11 pushes the entry {address register, rot}.
  - A push while full is dropped and sets wbuf_ovf_h. A pop in the same cycle does not make room.
  - A push while empty is visible to the FSM on the next cycle.
- Occupancy flags:
  - Pointers are log2(WDEPTH)+1 bits wide; wrap is handled by the MSB.
  - wbuf_full_h and wbuf_empty_h are registered-pointer derived and combinational from the pointers.
- Output drive:
  - ca_out_h = rot when ds_h != 00, else all ones.
  - mb_l = ~mmux when mbus_ena_h=1, else all ones.
- CMI FSM (states IDLE, ADDR, DATA):
  - IDLE: cmi_req_h = ~wbuf_empty_h. On cmi_req_h & cmi_grant_h, go to ADDR.
  - ADDR: cmi_drv_h=1; cmi_out_h = head address zero-extended to NLANE. Always go to DATA.
  - DATA: cmi_drv_h=1; cmi_out_h = head data. Pop the head at the end of the cycle.
    - Next state is ADDR if the buffer holds at least 2 entries and cmi_grant_h=1 (back-to-back, cmi_req_h stays 1).
    - Otherwise next state is IDLE.
  - Grant dropping during ADDR or DATA does not abort the transfer.
- Latency:
  - A push into an empty buffer with grant held high gives cmi_req_h at push+1, ADDR at push+2 and DATA at push+3.
  - The minimum drain rate is 2 cycles per entry.

Optional Feature:
- Macro MDR_PARITY_EN.
- Defined:
  - Adds input cmi_par_h (odd parity over cmi_h, captured alongside the CMI data register).
  - Adds output mdr_par_h, the odd parity of the MDR, registered with it.
  - Adds output cmi_perr_h, a sticky flag set when a captured word fails its parity check and cleared only by reset.
  - Each write-buffer entry stores a parity bit. During DATA that bit is driven on an added output cmi_par_out_h; the output is 1 when not driving.
- Undefined:
  - None of these ports exist and no parity logic is present.

Test Plan:
- Reset: assert reset_h mid-DATA -> next sample shows cmi_drv_h=0, cmi_out_h all ones, wbuf_empty_h=1, MDR=0.
- Rotate and load: NLANE=4, wbus_h=4'b1001, ds_h=10, dr_h=01, cs_h=01 -> MDR=4'b1100. Then ms_h=00 with mbus_ena_h=1 -> mb_l=4'b0011.
- Second-reference merge: MDR=4'b0000, ds_h=10, wbus_h=4'b1111, dr_h=10, cs_h=10 -> MDR=4'b1100.
- Drain: push three entries (address 3'b101, data 4'hA, 4'h5, 4'hF) with grant held -> CMI sequence is addr 4'h5, data 4'hA, addr 4'h5, data 4'h5, addr 4'h5, data 4'hF. cmi_req_h then drops and wbuf_empty_h=1.
- Full/overflow: WDEPTH=4, grant low, five pushes -> wbuf_full_h=1 after the fourth push, wbuf_ovf_h=1 after the fifth. Draining afterwards returns only the first four entries.
- Simultaneous push and pop at DATA when not full -> occupancy unchanged and the entry order is preserved.

Source files
------------

// File: rtl/mdr_wbuf_slice.sv
// Memory data register slice: lane rotator into the MDR, a small write buffer and a
// CMI drain sequencer. Optional parity support is enabled by defining MDR_PARITY_EN.
module mdr_wbuf_slice #(
    parameter int NLANE  = 4,
    parameter int RW     = 2,
    parameter int AW     = 3,
    parameter int WDEPTH = 4
) (
    input  logic             b_clk_l,
    input  logic             reset_h,
    input  logic [NLANE-1:0] wbus_h,
    input  logic [NLANE-1:0] ca_h,
    output logic [NLANE-1:0] ca_out_h,
    input  logic [NLANE-1:0] cmi_h,
    input  logic             snapshot_cmi_l,
    input  logic [AW-1:0]    pa_h,
    input  logic             are_l,
    input  logic [1:0]       ds_h,
    input  logic [RW-1:0]    dr_h,
    input  logic [1:0]       cs_h,
    input  logic [1:0]       ms_h,
    input  logic             mbus_ena_h,
    output logic [NLANE-1:0] mb_l,
    input  logic             cmi_grant_h,
    output logic             cmi_req_h,
    output logic             cmi_drv_h,
    output logic [NLANE-1:0] cmi_out_h,
`ifdef MDR_PARITY_EN
    input  logic             cmi_par_h,
    output logic             mdr_par_h,
    output logic             cmi_perr_h,
    output logic             cmi_par_out_h,
`endif
    output logic             wbuf_full_h,
    output logic             wbuf_empty_h,
    output logic             wbuf_ovf_h
);
    localparam int PW = $clog2(WDEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t             state_reg;
    logic [NLANE-1:0]   mdr_reg, mdr_next;
    logic [NLANE-1:0]   cmi_data_reg;
    logic [AW-1:0]      addr_reg;
    logic               ovf_reg;
    logic [NLANE-1:0]   dbus, rot, merge_mask, mmux;
    logic [2*NLANE-1:0] rot_wide;

    logic [NLANE-1:0]   wb_data_mem [WDEPTH];
    logic [AW-1:0]      wb_addr_mem [WDEPTH];
    logic [NLANE-1:0]   head_data_reg;
    logic [AW-1:0]      head_addr_reg;
    logic [PW:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next, occupancy;
    logic               push, push_ok, pop, more_queued;

    always_comb begin
        dbus = '0;
        case (ds_h)
            2'b00:   dbus = ca_h;
            2'b01:   dbus = cmi_data_reg;
            2'b10:   dbus = wbus_h;
            default: dbus = '0;
        endcase
    end

    // Doubling the word turns a logical shift into a rotate.
    assign rot_wide = {dbus, dbus} >> dr_h;
    assign rot      = rot_wide[NLANE-1:0];

    // Merge writes lane gi only when it is among the top dr_h lanes.
    generate
        for (genvar gi = 0; gi < NLANE; gi++) begin : g_mask
            assign merge_mask[gi] = ({1'b0, dr_h} + (RW+1)'(gi)) >= (RW+1)'(NLANE);
        end
    endgenerate

    always_comb begin
        mdr_next = mdr_reg;
        case (cs_h)
            2'b01:   mdr_next = rot;
            2'b10:   mdr_next = (mdr_reg & ~merge_mask) | (rot & merge_mask);
            default: mdr_next = mdr_reg;
        endcase
    end

    assign occupancy    = wr_ptr_reg - rd_ptr_reg;
    assign wbuf_empty_h = (wr_ptr_reg == rd_ptr_reg);
    assign wbuf_full_h  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                          (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign wbuf_ovf_h   = ovf_reg;
    assign push         = (cs_h == 2'b11);
    assign push_ok      = push && !wbuf_full_h;
    assign pop          = (state_reg == DATA);
    assign rd_ptr_next  = rd_ptr_reg + {{PW{1'b0}}, pop};
    assign more_queued  = (occupancy >= (PW+1)'(2)) && cmi_grant_h;

    always_ff @(posedge b_clk_l or posedge reset_h) begin
        if (reset_h) begin
            mdr_reg      <= '0;
            addr_reg     <= '0;
            cmi_data_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            mdr_reg <= mdr_next;
            if (!are_l)
                addr_reg <= pa_h;
            if (!snapshot_cmi_l)
                cmi_data_reg <= cmi_h;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (push && wbuf_full_h)
                ovf_reg <= 1'b1;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Head is re-read every cycle from the post-pop pointer so it is fresh for ADDR.
    always_ff @(posedge b_clk_l) begin
        if (push_ok) begin
            wb_data_mem[wr_ptr_reg[PW-1:0]] <= rot;
            wb_addr_mem[wr_ptr_reg[PW-1:0]] <= addr_reg;
        end
        head_data_reg <= wb_data_mem[rd_ptr_next[PW-1:0]];
        head_addr_reg <= wb_addr_mem[rd_ptr_next[PW-1:0]];
    end

    always_ff @(posedge b_clk_l or posedge reset_h) begin
        if (reset_h) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (!wbuf_empty_h && cmi_grant_h) state_reg <= ADDR;
                ADDR:    state_reg <= DATA;
                DATA:    state_reg <= more_queued ? ADDR : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The request is held for the whole transfer so the bus is kept across back-to-back entries.
    assign cmi_req_h = (state_reg == IDLE) ? !wbuf_empty_h : 1'b1;
    assign cmi_drv_h = (state_reg != IDLE);
    assign cmi_out_h = (state_reg == ADDR) ? NLANE'(head_addr_reg) :
                       (state_reg == DATA) ? head_data_reg : '1;

    always_comb begin
        mmux = mdr_reg;
        case (ms_h)
            2'b00:   mmux = mdr_reg;
            2'b01:   mmux = head_data_reg;
            2'b10:   mmux = wbus_h;
            default: mmux = NLANE'(addr_reg);
        endcase
    end

    assign mb_l     = mbus_ena_h ? ~mmux : '1;
    assign ca_out_h = (ds_h != 2'b00) ? rot : '1;

`ifdef MDR_PARITY_EN
    logic             cmi_par_reg, mdr_par_reg, perr_reg, head_par_reg;
    logic             wb_par_mem [WDEPTH];

    always_ff @(posedge b_clk_l or posedge reset_h) begin
        if (reset_h) begin
            cmi_par_reg <= 1'b1;
            mdr_par_reg <= 1'b1;
            perr_reg    <= 1'b0;
        end else begin
            if (!snapshot_cmi_l)
                cmi_par_reg <= cmi_par_h;
            mdr_par_reg <= ~^mdr_next;
            // An even count of ones across data plus parity marks a bad capture.
            if (!(^{cmi_data_reg, cmi_par_reg}))
                perr_reg <= 1'b1;
        end
    end

    always_ff @(posedge b_clk_l) begin
        if (push_ok)
            wb_par_mem[wr_ptr_reg[PW-1:0]] <= ~^rot;
        head_par_reg <= wb_par_mem[rd_ptr_next[PW-1:0]];
    end

    assign mdr_par_h     = mdr_par_reg;
    assign cmi_perr_h    = perr_reg;
    assign cmi_par_out_h = (state_reg == DATA) ? head_par_reg : 1'b1;
`endif

endmodule

// File: tb/tb_mdr_wbuf_slice.sv
// Directed bench for mdr_wbuf_slice: rotator/MDR, merge, write-buffer drain, overflow, reset.
module tb_mdr_wbuf_slice;
    logic       b_clk_l = 1'b0;
    logic       reset_h;
    logic [3:0] wbus_h, ca_h, ca_out_h, cmi_h, mb_l, cmi_out_h;
    logic       snapshot_cmi_l, are_l, mbus_ena_h, cmi_grant_h;
    logic [2:0] pa_h;
    logic [1:0] ds_h, cs_h, ms_h, dr_h;
    logic       cmi_req_h, cmi_drv_h, wbuf_full_h, wbuf_empty_h, wbuf_ovf_h;

    int n_checks = 0;
    int n_fail   = 0;

    mdr_wbuf_slice #(.NLANE(4), .RW(2), .AW(3), .WDEPTH(4)) dut (
        .b_clk_l(b_clk_l), .reset_h(reset_h), .wbus_h(wbus_h), .ca_h(ca_h),
        .ca_out_h(ca_out_h), .cmi_h(cmi_h), .snapshot_cmi_l(snapshot_cmi_l),
        .pa_h(pa_h), .are_l(are_l), .ds_h(ds_h), .dr_h(dr_h), .cs_h(cs_h),
        .ms_h(ms_h), .mbus_ena_h(mbus_ena_h), .mb_l(mb_l),
        .cmi_grant_h(cmi_grant_h), .cmi_req_h(cmi_req_h), .cmi_drv_h(cmi_drv_h),
        .cmi_out_h(cmi_out_h), .wbuf_full_h(wbuf_full_h),
        .wbuf_empty_h(wbuf_empty_h), .wbuf_ovf_h(wbuf_ovf_h)
    );

    always #5 b_clk_l = ~b_clk_l;

    task automatic step();
        @(posedge b_clk_l);
        #1;
    endtask

    task automatic idle_inputs();
        cs_h = 2'b00; ds_h = 2'b11; dr_h = 2'b00; ms_h = 2'b00;
        mbus_ena_h = 1'b0; are_l = 1'b1; snapshot_cmi_l = 1'b1;
    endtask

    task automatic test_reset();
        reset_h = 1'b1; idle_inputs();
        wbus_h = '0; ca_h = '0; cmi_h = '0; pa_h = '0; cmi_grant_h = 1'b0;
        mbus_ena_h = 1'b1;
        #1;
        n_checks++; if (cmi_req_h !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", cmi_req_h); end
        n_checks++; if (cmi_drv_h !== 1'b0) begin n_fail++; $display("FAIL reset_drv got %b want 0", cmi_drv_h); end
        n_checks++; if (cmi_out_h !== 4'hF) begin n_fail++; $display("FAIL reset_out got %h want f", cmi_out_h); end
        n_checks++; if (wbuf_empty_h !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", wbuf_empty_h); end
        n_checks++; if (wbuf_full_h !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", wbuf_full_h); end
        n_checks++; if (wbuf_ovf_h !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", wbuf_ovf_h); end
        n_checks++; if (mb_l !== 4'hF) begin n_fail++; $display("FAIL reset_mdr mb_l got %b want 1111", mb_l); end
        step();
        reset_h = 1'b0; mbus_ena_h = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_rotate_load();
        wbus_h = 4'b1001; ds_h = 2'b10; dr_h = 2'b01; cs_h = 2'b01;
        #1;
        n_checks++; if (ca_out_h !== 4'b1100) begin n_fail++; $display("FAIL rot_ca_out got %b want 1100", ca_out_h); end
        step();
        cs_h = 2'b00; ds_h = 2'b00; ms_h = 2'b00; mbus_ena_h = 1'b1;
        #1;
        n_checks++; if (mb_l !== 4'b0011) begin n_fail++; $display("FAIL rot_load mb_l got %b want 0011", mb_l); end
        n_checks++; if (ca_out_h !== 4'b1111) begin n_fail++; $display("FAIL ca_out_idle got %b want 1111", ca_out_h); end
        ms_h = 2'b10; wbus_h = 4'b0110;
        #1;
        n_checks++; if (mb_l !== 4'b1001) begin n_fail++; $display("FAIL mbus_wbus got %b want 1001", mb_l); end
        mbus_ena_h = 1'b0;
        #1;
        n_checks++; if (mb_l !== 4'b1111) begin n_fail++; $display("FAIL mbus_off got %b want 1111", mb_l); end
        idle_inputs();
        $display("rotate_load: mb_l=%b", mb_l);
    endtask

    task automatic test_merge();
        ds_h = 2'b11; cs_h = 2'b01;
        step();
        ds_h = 2'b10; wbus_h = 4'b1111; dr_h = 2'b10; cs_h = 2'b10;
        step();
        cs_h = 2'b00; ms_h = 2'b00; mbus_ena_h = 1'b1;
        #1;
        n_checks++; if (mb_l !== 4'b0011) begin n_fail++; $display("FAIL merge_dr2 mb_l got %b want 0011", mb_l); end
        ds_h = 2'b11; dr_h = 2'b00; cs_h = 2'b10;
        step();
        cs_h = 2'b00;
        #1;
        n_checks++; if (mb_l !== 4'b0011) begin n_fail++; $display("FAIL merge_dr0 mb_l got %b want 0011", mb_l); end
        ds_h = 2'b11; dr_h = 2'b11; cs_h = 2'b10;
        step();
        cs_h = 2'b00;
        #1;
        n_checks++; if (mb_l !== 4'b1111) begin n_fail++; $display("FAIL merge_dr3 mb_l got %b want 1111", mb_l); end
        idle_inputs();
        $display("merge: mb_l=%b", mb_l);
    endtask

    task automatic test_drain();
        logic [3:0] exp_out [5];
        logic       exp_drv [5];
        exp_out = '{4'h5, 4'h5, 4'h5, 4'hF, 4'hF};
        exp_drv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        pa_h = 3'b101; are_l = 1'b0;
        step();
        are_l = 1'b1; cmi_grant_h = 1'b1;
        ds_h = 2'b10; dr_h = 2'b00; cs_h = 2'b11; wbus_h = 4'hA;
        step();
        n_checks++; if (cmi_req_h !== 1'b1) begin n_fail++; $display("FAIL drain_req got %b want 1", cmi_req_h); end
        n_checks++; if (cmi_drv_h !== 1'b0) begin n_fail++; $display("FAIL drain_req_drv got %b want 0", cmi_drv_h); end
        wbus_h = 4'h5;
        step();
        n_checks++; if (cmi_drv_h !== 1'b1 || cmi_out_h !== 4'h5) begin n_fail++; $display("FAIL drain_addr0 got drv=%b out=%h want drv=1 out=5", cmi_drv_h, cmi_out_h); end
        wbus_h = 4'hF;
        step();
        cs_h = 2'b00;
        n_checks++; if (cmi_drv_h !== 1'b1 || cmi_out_h !== 4'hA) begin n_fail++; $display("FAIL drain_data0 got drv=%b out=%h want drv=1 out=a", cmi_drv_h, cmi_out_h); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (cmi_drv_h !== exp_drv[i] || cmi_out_h !== exp_out[i]) begin
                n_fail++;
                $display("FAIL drain_seq[%0d] got drv=%b out=%h want drv=%b out=%h", i, cmi_drv_h, cmi_out_h, exp_drv[i], exp_out[i]);
            end
        end
        n_checks++; if (cmi_req_h !== 1'b0 || wbuf_empty_h !== 1'b1) begin n_fail++; $display("FAIL drain_end got req=%b empty=%b want req=0 empty=1", cmi_req_h, wbuf_empty_h); end
        cmi_grant_h = 1'b0; idle_inputs();
        $display("drain: three entries drained");
    endtask

    task automatic test_full_ovf();
        logic [3:0] vals [5];
        logic [3:0] exp_out [9];
        logic       exp_drv [9];
        vals    = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
        exp_out = '{4'h2, 4'h1, 4'h2, 4'h2, 4'h2, 4'h3, 4'h2, 4'h4, 4'hF};
        exp_drv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        cmi_grant_h = 1'b0; pa_h = 3'b010; are_l = 1'b0;
        step();
        are_l = 1'b1; ds_h = 2'b10; dr_h = 2'b00; cs_h = 2'b11;
        for (int k = 0; k < 5; k++) begin
            wbus_h = vals[k];
            step();
            if (k == 2) begin
                n_checks++; if (wbuf_full_h !== 1'b0) begin n_fail++; $display("FAIL full_at3 got %b want 0", wbuf_full_h); end
            end
            if (k == 3) begin
                n_checks++; if (wbuf_full_h !== 1'b1 || wbuf_ovf_h !== 1'b0) begin n_fail++; $display("FAIL full_at4 got full=%b ovf=%b want 1 0", wbuf_full_h, wbuf_ovf_h); end
            end
            if (k == 4) begin
                n_checks++; if (wbuf_full_h !== 1'b1 || wbuf_ovf_h !== 1'b1) begin n_fail++; $display("FAIL ovf_at5 got full=%b ovf=%b want 1 1", wbuf_full_h, wbuf_ovf_h); end
            end
        end
        cs_h = 2'b00; cmi_grant_h = 1'b1;
        n_checks++; if (cmi_req_h !== 1'b1 || cmi_drv_h !== 1'b0) begin n_fail++; $display("FAIL full_req got req=%b drv=%b want 1 0", cmi_req_h, cmi_drv_h); end
        for (int i = 0; i < 9; i++) begin
            step();
            n_checks++;
            if (cmi_drv_h !== exp_drv[i] || cmi_out_h !== exp_out[i]) begin
                n_fail++;
                $display("FAIL full_drain[%0d] got drv=%b out=%h want drv=%b out=%h", i, cmi_drv_h, cmi_out_h, exp_drv[i], exp_out[i]);
            end
        end
        n_checks++; if (wbuf_empty_h !== 1'b1 || wbuf_ovf_h !== 1'b1) begin n_fail++; $display("FAIL full_end got empty=%b ovf=%b want 1 1", wbuf_empty_h, wbuf_ovf_h); end
        cmi_grant_h = 1'b0; idle_inputs();
        $display("full_ovf: four of five entries drained");
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_out [4];
        logic       exp_drv [4];
        exp_out = '{4'h8, 4'h2, 4'h9, 4'hF};
        exp_drv = '{1'b1, 1'b1, 1'b1, 1'b0};
        cmi_grant_h = 1'b1; ds_h = 2'b10; dr_h = 2'b00;
        cs_h = 2'b11; wbus_h = 4'h7;
        step();
        wbus_h = 4'h8;
        step();
        cs_h = 2'b00;
        n_checks++; if (cmi_drv_h !== 1'b1 || cmi_out_h !== 4'h2) begin n_fail++; $display("FAIL b2b_addr0 got drv=%b out=%h want drv=1 out=2", cmi_drv_h, cmi_out_h); end
        step();
        cs_h = 2'b11; wbus_h = 4'h9;
        n_checks++; if (cmi_out_h !== 4'h7 || wbuf_full_h !== 1'b0) begin n_fail++; $display("FAIL b2b_data0 got out=%h full=%b want out=7 full=0", cmi_out_h, wbuf_full_h); end
        step();
        cs_h = 2'b00;
        n_checks++; if (cmi_out_h !== 4'h2 || wbuf_empty_h !== 1'b0) begin n_fail++; $display("FAIL b2b_addr1 got out=%h empty=%b want out=2 empty=0", cmi_out_h, wbuf_empty_h); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (cmi_drv_h !== exp_drv[i] || cmi_out_h !== exp_out[i]) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d] got drv=%b out=%h want drv=%b out=%h", i, cmi_drv_h, cmi_out_h, exp_drv[i], exp_out[i]);
            end
        end
        n_checks++; if (wbuf_empty_h !== 1'b1) begin n_fail++; $display("FAIL b2b_end empty got %b want 1", wbuf_empty_h); end
        cmi_grant_h = 1'b0; idle_inputs();
        $display("back_to_back: push during DATA kept order");
    endtask

    task automatic test_reset_mid_burst();
        ds_h = 2'b10; dr_h = 2'b00; wbus_h = 4'hC; cs_h = 2'b01;
        step();
        cmi_grant_h = 1'b1; cs_h = 2'b11;
        step();
        cs_h = 2'b00;
        step();
        step();
        n_checks++; if (cmi_drv_h !== 1'b1 || cmi_out_h !== 4'hC) begin n_fail++; $display("FAIL rst_pre_data got drv=%b out=%h want drv=1 out=c", cmi_drv_h, cmi_out_h); end
        reset_h = 1'b1; ms_h = 2'b00; mbus_ena_h = 1'b1;
        #1;
        n_checks++; if (cmi_drv_h !== 1'b0 || cmi_out_h !== 4'hF) begin n_fail++; $display("FAIL rst_mid_cmi got drv=%b out=%h want drv=0 out=f", cmi_drv_h, cmi_out_h); end
        n_checks++; if (wbuf_empty_h !== 1'b1 || cmi_req_h !== 1'b0) begin n_fail++; $display("FAIL rst_mid_buf got empty=%b req=%b want 1 0", wbuf_empty_h, cmi_req_h); end
        n_checks++; if (mb_l !== 4'hF) begin n_fail++; $display("FAIL rst_mid_mdr mb_l got %b want 1111", mb_l); end
        step();
        reset_h = 1'b0; cmi_grant_h = 1'b0; idle_inputs();
        $display("reset_mid_burst: CMI released");
    endtask

    initial begin
        test_reset();
        test_rotate_load();
        test_merge();
        test_drain();
        test_full_ovf();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
